// File: rtl/spi_share_arbiter.sv
// Round-robin arbiter sharing one SPI host between several chip-select clients,
// with programmable CS setup, hold and inter-grant gap timing.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | all CS high, waiting for any request
// ST_SETUP  | CS low, counting setup cycles before bytes may flow
// ST_ACTIVE | bytes steered between granted requester and host
// ST_HOLD   | host idle, CS still low for the hold time
// ST_GAP    | all CS high, enforcing minimum gap before the next grant
module spi_share_arbiter #(
    parameter int NumReq        = 3,
    parameter int DataWidth     = 8,
    parameter int CsSetupCycles = 2,
    parameter int CsHoldCycles  = 2,
    parameter int CsGapCycles   = 1
) (
    input  logic                          clk_sys_i,
    input  logic                          rst_sys_i,
    input  logic [NumReq-1:0]             req_i,
    output logic [NumReq-1:0]             grant_o,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_data_o,
    output logic                          host_valid_o,
    output logic [DataWidth-1:0]          host_data_o,
    input  logic                          host_ready_i,
    input  logic                          host_rvalid_i,
    input  logic [DataWidth-1:0]          host_rdata_i,
    input  logic                          host_busy_i,
    output logic [NumReq-1:0]             cs_no,
    output logic                          busy_o
);

    localparam int PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int MaxSH  = (CsSetupCycles > CsHoldCycles) ? CsSetupCycles : CsHoldCycles;
    localparam int MaxCyc = (MaxSH > CsGapCycles) ? MaxSH : CsGapCycles;
    localparam int CntW   = (MaxCyc > 0) ? $clog2(MaxCyc + 1) : 1;

    localparam logic [CntW-1:0] SetupLast = CntW'((CsSetupCycles > 0) ? CsSetupCycles - 1 : 0);
    localparam logic [CntW-1:0] HoldLast  = CntW'((CsHoldCycles > 0) ? CsHoldCycles - 1 : 0);
    localparam logic [CntW-1:0] GapLast   = CntW'((CsGapCycles > 0) ? CsGapCycles - 1 : 0);
    localparam logic [PtrW-1:0] LastIdx   = PtrW'(NumReq - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t            state;
    logic [CntW-1:0]   cnt;
    logic [PtrW-1:0]   ptr;
    logic [PtrW-1:0]   g_idx;
    logic [PtrW-1:0]   pick_idx;
    logic [NumReq-1:0] pick_onehot;
    logic              pick_found;
    logic              granted_req;
    logic              end_of_grant;
    logic              release_now;
    logic              active;

    // First requester at or after the pointer, wrapping at NumReq.
    always_comb begin
        int idx;
        idx        = 0;
        pick_idx   = ptr;
        pick_found = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(ptr) + k) % NumReq;
            if (!pick_found && req_i[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PtrW'(idx);
            end
        end
    end

    assign pick_onehot = {{(NumReq-1){1'b0}}, 1'b1} << pick_idx;

    assign granted_req  = |(req_i & grant_o);
    assign end_of_grant = ((state == ST_SETUP) && !granted_req) ||
                          ((state == ST_ACTIVE) && !granted_req && !host_busy_i);
    // With zero hold time the CS is released on the same edge the grant ends.
    assign release_now  = ((state == ST_HOLD) && (cnt == HoldLast)) ||
                          (end_of_grant && (CsHoldCycles == 0));

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state   <= ST_IDLE;
            grant_o <= '0;
            cs_no   <= '1;
            ptr     <= '0;
            g_idx   <= '0;
            cnt     <= '0;
        end else if (release_now) begin
            grant_o <= '0;
            cs_no   <= '1;
            ptr     <= (g_idx == LastIdx) ? '0 : g_idx + PtrW'(1);
            cnt     <= '0;
            state   <= (CsGapCycles == 0) ? ST_IDLE : ST_GAP;
        end else if (end_of_grant) begin
            state <= ST_HOLD;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_o <= pick_onehot;
                        cs_no   <= ~pick_onehot;
                        g_idx   <= pick_idx;
                        cnt     <= '0;
                        state   <= (CsSetupCycles == 0) ? ST_ACTIVE : ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SetupLast) begin
                        state <= ST_ACTIVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                ST_ACTIVE: begin
                    cnt <= '0;
                end
                ST_HOLD: begin
                    cnt <= cnt + CntW'(1);
                end
                ST_GAP: begin
                    if (cnt == GapLast) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign active       = (state == ST_ACTIVE);
    assign busy_o       = (state != ST_IDLE);
    assign host_valid_o = active && |(req_valid_i & grant_o);
    assign req_ready_o  = active ? (grant_o & {NumReq{host_ready_i}}) : '0;
    // Receive path stays open through HOLD so late bytes reach the requester.
    assign rsp_valid_o  = grant_o & {NumReq{host_rvalid_i}};
    assign rsp_data_o   = host_rdata_i;

    always_comb begin
        host_data_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant_o[i]) begin
                host_data_o = req_data_i[i*DataWidth +: DataWidth];
            end
        end
    end

endmodule

// File: tb/tb_spi_share_arbiter.sv
// Directed bench for spi_share_arbiter: default timing instance plus a
// zero setup/hold/gap instance sharing clock and reset.
module tb_spi_share_arbiter;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic rst_sys;

    logic [2:0]  req_a, grant_a, req_valid_a, req_ready_a, rsp_valid_a, cs_a;
    logic [23:0] req_data_a;
    logic [7:0]  rsp_data_a, host_data_a, host_rdata_a;
    logic        host_valid_a, host_ready_a, host_rvalid_a, host_busy_a, busy_a;

    logic [2:0]  req_b, grant_b, req_valid_b, req_ready_b, rsp_valid_b, cs_b;
    logic [23:0] req_data_b;
    logic [7:0]  rsp_data_b, host_data_b, host_rdata_b;
    logic        host_valid_b, host_ready_b, host_rvalid_b, host_busy_b, busy_b;

    int vectors = 0;
    int miscompares = 0;

    spi_share_arbiter #(
        .NumReq(3), .DataWidth(8), .CsSetupCycles(2), .CsHoldCycles(2), .CsGapCycles(1)
    ) dut_a (
        .clk_sys_i(clk_sys), .rst_sys_i(rst_sys),
        .req_i(req_a), .grant_o(grant_a),
        .req_valid_i(req_valid_a), .req_data_i(req_data_a), .req_ready_o(req_ready_a),
        .rsp_valid_o(rsp_valid_a), .rsp_data_o(rsp_data_a),
        .host_valid_o(host_valid_a), .host_data_o(host_data_a), .host_ready_i(host_ready_a),
        .host_rvalid_i(host_rvalid_a), .host_rdata_i(host_rdata_a), .host_busy_i(host_busy_a),
        .cs_no(cs_a), .busy_o(busy_a)
    );

    spi_share_arbiter #(
        .NumReq(3), .DataWidth(8), .CsSetupCycles(0), .CsHoldCycles(0), .CsGapCycles(0)
    ) dut_b (
        .clk_sys_i(clk_sys), .rst_sys_i(rst_sys),
        .req_i(req_b), .grant_o(grant_b),
        .req_valid_i(req_valid_b), .req_data_i(req_data_b), .req_ready_o(req_ready_b),
        .rsp_valid_o(rsp_valid_b), .rsp_data_o(rsp_data_b),
        .host_valid_o(host_valid_b), .host_data_o(host_data_b), .host_ready_i(host_ready_b),
        .host_rvalid_i(host_rvalid_b), .host_rdata_i(host_rdata_b), .host_busy_i(host_busy_b),
        .cs_no(cs_b), .busy_o(busy_b)
    );

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        rst_sys = 1'b1;
        req_a = 3'b111; req_valid_a = 3'b111; req_data_a = 24'h0;
        host_ready_a = 1'b1; host_rvalid_a = 1'b1; host_rdata_a = 8'h0; host_busy_a = 1'b0;
        req_b = 3'b111; req_valid_b = 3'b111; req_data_b = 24'h0;
        host_ready_b = 1'b1; host_rvalid_b = 1'b1; host_rdata_b = 8'h0; host_busy_b = 1'b0;
        cyc();
        cyc();
        vectors++;
        if ({cs_a, grant_a, busy_a, host_valid_a, req_ready_a, rsp_valid_a} !==
            {3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_a: got %b expected %b",
                     {cs_a, grant_a, busy_a, host_valid_a, req_ready_a, rsp_valid_a}, 14'b11100000000000);
        end
        vectors++;
        if ({cs_b, grant_b, busy_b, host_valid_b, req_ready_b, rsp_valid_b} !==
            {3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_b: got %b expected %b",
                     {cs_b, grant_b, busy_b, host_valid_b, req_ready_b, rsp_valid_b}, 14'b11100000000000);
        end
        rst_sys = 1'b0;
        req_a = 3'b000; req_valid_a = 3'b000; host_rvalid_a = 1'b0;
        req_b = 3'b000; req_valid_b = 3'b000; host_rvalid_b = 1'b0;
        cyc();
    endtask

    task automatic test_round_robin();
        logic [2:0] served;
        logic [2:0] prev_grant;
        logic [7:0] order;
        int         ngrants;
        int         high_run;
        int         n;
        served = 3'b000; prev_grant = 3'b000; order = 8'h0;
        ngrants = 0; high_run = 0; n = 0;
        req_a = 3'b111; req_valid_a = 3'b111; req_data_a = {8'h33, 8'h22, 8'h11};
        host_ready_a = 1'b1; host_busy_a = 1'b0;
        while (ngrants < 4 && n < 300) begin
            cyc();
            n++;
            vectors++;
            if ((cs_a !== ~grant_a) || ($countones(~cs_a) > 1)) begin
                miscompares++;
                $display("FAIL rr_cs_invariant: cs_no %b grant %b, required cs_no == ~grant with at most one low",
                         cs_a, grant_a);
            end
            if (grant_a != 3'b000 && prev_grant == 3'b000) begin
                if (ngrants > 0) begin
                    vectors++;
                    if (high_run != 2) begin
                        miscompares++;
                        $display("FAIL rr_gap: got %0d all-high cycles expected 2", high_run);
                    end
                end
                order = {order[5:0], (grant_a[2] ? 2'd2 : grant_a[1] ? 2'd1 : 2'd0)};
                ngrants++;
            end
            high_run = (cs_a == 3'b111) ? high_run + 1 : 0;
            for (int i = 0; i < 3; i++) begin
                if (req_ready_a[i] && req_valid_a[i]) begin
                    vectors++;
                    if (host_data_a !== 8'(8'h11 * (i + 1))) begin
                        miscompares++;
                        $display("FAIL rr_data: got %h expected %h", host_data_a, 8'(8'h11 * (i + 1)));
                    end
                    served[i] = 1'b1;
                end
                if (!grant_a[i]) served[i] = 1'b0;
            end
            prev_grant  = grant_a;
            req_a       = ~served;
            req_valid_a = ~served;
        end
        vectors++;
        if (ngrants < 4) begin
            miscompares++;
            $display("FAIL rr_timeout: got %0d grants expected 4", ngrants);
        end
        vectors++;
        if (order !== 8'b00_01_10_00) begin
            miscompares++;
            $display("FAIL rr_order: got %b expected %b", order, 8'b00011000);
        end
        req_a = 3'b000; req_valid_a = 3'b000;
        repeat (8) cyc();
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_drain: busy got %b expected 0", busy_a);
        end
    endtask

    task automatic test_single();
        cyc();
        req_a = 3'b001; req_valid_a = 3'b001; req_data_a = {16'h0, 8'hA5};
        host_ready_a = 1'b1; host_busy_a = 1'b0;
        #1;
        vectors++;
        if ({cs_a, grant_a, busy_a, host_valid_a} !== {3'b111, 3'b000, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL single_c0: got %b expected %b", {cs_a, grant_a, busy_a, host_valid_a}, 8'b11100000);
        end
        cyc(); #1;
        vectors++;
        if ({cs_a, grant_a, busy_a, host_valid_a} !== {3'b110, 3'b001, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL single_setup1: got %b expected %b", {cs_a, grant_a, busy_a, host_valid_a}, 8'b11000110);
        end
        cyc(); #1;
        vectors++;
        if ({cs_a, host_valid_a} !== {3'b110, 1'b0}) begin
            miscompares++;
            $display("FAIL single_setup2: got %b expected %b", {cs_a, host_valid_a}, 4'b1100);
        end
        cyc(); #1;
        vectors++;
        if ({host_valid_a, host_data_a, req_ready_a} !== {1'b1, 8'hA5, 3'b001}) begin
            miscompares++;
            $display("FAIL single_byte1: got %h expected %h", {host_valid_a, host_data_a, req_ready_a}, {1'b1, 8'hA5, 3'b001});
        end
        cyc();
        req_data_a = {16'h0, 8'h3C}; host_busy_a = 1'b1;
        #1;
        vectors++;
        if ({host_valid_a, host_data_a} !== {1'b1, 8'h3C}) begin
            miscompares++;
            $display("FAIL single_byte2: got %h expected %h", {host_valid_a, host_data_a}, {1'b1, 8'h3C});
        end
        cyc();
        req_a = 3'b000; req_valid_a = 3'b000; host_rvalid_a = 1'b1; host_rdata_a = 8'hC3;
        #1;
        vectors++;
        if ({cs_a, host_valid_a, busy_a, rsp_valid_a, rsp_data_a} !== {3'b110, 1'b0, 1'b1, 3'b001, 8'hC3}) begin
            miscompares++;
            $display("FAIL single_busy_hold: got %h expected %h",
                     {cs_a, host_valid_a, busy_a, rsp_valid_a, rsp_data_a}, {3'b110, 1'b0, 1'b1, 3'b001, 8'hC3});
        end
        cyc();
        host_busy_a = 1'b0; host_rvalid_a = 1'b0;
        #1;
        vectors++;
        if (cs_a !== 3'b110) begin
            miscompares++;
            $display("FAIL single_busy_fall: cs got %b expected 110", cs_a);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(); #1;
            vectors++;
            if ({cs_a, grant_a} !== {3'b110, 3'b001}) begin
                miscompares++;
                $display("FAIL single_hold: got %b expected 110001", {cs_a, grant_a});
            end
        end
        cyc(); #1;
        vectors++;
        if ({cs_a, grant_a, busy_a} !== {3'b111, 3'b000, 1'b1}) begin
            miscompares++;
            $display("FAIL single_release: got %b expected 1110001", {cs_a, grant_a, busy_a});
        end
        cyc(); #1;
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: busy got %b expected 0", busy_a);
        end
    endtask

    task automatic test_late_receive();
        cyc();
        req_a = 3'b100; req_valid_a = 3'b000; host_busy_a = 1'b0;
        cyc(); cyc();
        cyc();
        req_a = 3'b000;
        #1;
        vectors++;
        if ({cs_a, grant_a} !== {3'b011, 3'b100}) begin
            miscompares++;
            $display("FAIL late_active: got %b expected 011100", {cs_a, grant_a});
        end
        cyc(); #1;
        vectors++;
        if ({cs_a, rsp_valid_a} !== {3'b011, 3'b000}) begin
            miscompares++;
            $display("FAIL late_hold_quiet: got %b expected 011000", {cs_a, rsp_valid_a});
        end
        cyc();
        host_rvalid_a = 1'b1; host_rdata_a = 8'h5A;
        #1;
        vectors++;
        if ({rsp_valid_a, rsp_data_a} !== {3'b100, 8'h5A}) begin
            miscompares++;
            $display("FAIL late_rsp: got %h expected %h", {rsp_valid_a, rsp_data_a}, {3'b100, 8'h5A});
        end
        cyc(); #1;
        vectors++;
        if ({cs_a, rsp_valid_a} !== {3'b111, 3'b000}) begin
            miscompares++;
            $display("FAIL late_after_release: got %b expected 111000", {cs_a, rsp_valid_a});
        end
        host_rvalid_a = 1'b0;
        cyc(); #1;
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL late_idle: busy got %b expected 0", busy_a);
        end
    endtask

    task automatic test_abort_setup();
        cyc();
        req_a = 3'b010; req_valid_a = 3'b010; req_data_a = {8'h0, 8'h77, 8'h0};
        cyc(); #1;
        vectors++;
        if (cs_a !== 3'b101) begin
            miscompares++;
            $display("FAIL abort_cs_assert: got %b expected 101", cs_a);
        end
        cyc();
        req_a = 3'b000;
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({cs_a, host_valid_a, req_ready_a} !== {3'b101, 1'b0, 3'b000}) begin
                miscompares++;
                $display("FAIL abort_no_traffic: step %0d got %b expected 1010000", k, {cs_a, host_valid_a, req_ready_a});
            end
            cyc(); #1;
        end
        vectors++;
        if ({cs_a, busy_a, host_valid_a} !== {3'b111, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_gap: got %b expected 11110", {cs_a, busy_a, host_valid_a});
        end
        req_valid_a = 3'b000;
        cyc(); #1;
        vectors++;
        if ({cs_a, busy_a} !== {3'b111, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_idle: got %b expected 1110", {cs_a, busy_a});
        end
    endtask

    task automatic test_reset_mid_active();
        cyc();
        req_a = 3'b010; req_valid_a = 3'b010; req_data_a = {8'h0, 8'h99, 8'h0}; host_ready_a = 1'b1;
        cyc(); cyc(); cyc(); #1;
        vectors++;
        if ({host_valid_a, host_data_a} !== {1'b1, 8'h99}) begin
            miscompares++;
            $display("FAIL rstmid_active: got %h expected %h", {host_valid_a, host_data_a}, {1'b1, 8'h99});
        end
        rst_sys = 1'b1;
        cyc();
        rst_sys = 1'b0; req_a = 3'b111; req_valid_a = 3'b000;
        #1;
        vectors++;
        if ({cs_a, grant_a, busy_a, host_valid_a, req_ready_a} !== {3'b111, 3'b000, 1'b0, 1'b0, 3'b000}) begin
            miscompares++;
            $display("FAIL rstmid_cleared: got %b expected 11100000000",
                     {cs_a, grant_a, busy_a, host_valid_a, req_ready_a});
        end
        cyc(); #1;
        vectors++;
        if ({cs_a, grant_a} !== {3'b110, 3'b001}) begin
            miscompares++;
            $display("FAIL rstmid_regrant: got %b expected 110001", {cs_a, grant_a});
        end
        req_a = 3'b000;
        repeat (8) cyc();
    endtask

    task automatic test_zero_timing();
        cyc();
        req_b = 3'b010; req_valid_b = 3'b010; req_data_b = {8'h0, 8'hE1, 8'h0};
        host_ready_b = 1'b1; host_busy_b = 1'b0;
        #1;
        vectors++;
        if ({cs_b, host_valid_b} !== {3'b111, 1'b0}) begin
            miscompares++;
            $display("FAIL zero_c0: got %b expected 1110", {cs_b, host_valid_b});
        end
        cyc(); #1;
        vectors++;
        if ({cs_b, grant_b, host_valid_b, host_data_b, busy_b} !== {3'b101, 3'b010, 1'b1, 8'hE1, 1'b1}) begin
            miscompares++;
            $display("FAIL zero_active: got %h expected %h",
                     {cs_b, grant_b, host_valid_b, host_data_b, busy_b}, {3'b101, 3'b010, 1'b1, 8'hE1, 1'b1});
        end
        req_b = 3'b000; req_valid_b = 3'b000;
        cyc(); #1;
        vectors++;
        if ({cs_b, grant_b, busy_b} !== {3'b111, 3'b000, 1'b0}) begin
            miscompares++;
            $display("FAIL zero_release: got %b expected 1110000", {cs_b, grant_b, busy_b});
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_late_receive();
        test_abort_setup();
        test_reset_mid_active();
        test_zero_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
